// File: rtl/rdata_packetizer_if.sv
// AXI-Stream style bundle for the read-data path.
// The input side is unframed, so the slave view carries no tkeep/tlast.
interface rdata_packetizer_if #(
   parameter int DATA_WIDTH = 512
);
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tkeep;
   logic                    tlast;
   logic                    tvalid;
   logic                    tready;

   modport master (output tdata, tkeep, tlast, tvalid, input tready);
   modport slave  (input tdata, tvalid, output tready);
endinterface

// File: rtl/rdata_packetizer.sv
// Frames an unframed read-data beat stream into AXI-Stream packets of
// pkt_len beats. Partial packets are closed by flush or an idle timeout.
// Storage is two beats: H (decision register) and O (output register).
module rdata_packetizer #(
   parameter int DATA_WIDTH = 512,
   parameter int LEN_WIDTH  = 16,
   parameter int TO_WIDTH   = 16
) (
   input  logic                  axi_aclk,
   input  logic                  axi_aresetn,
   input  logic [LEN_WIDTH-1:0]  pkt_len,
   input  logic [TO_WIDTH-1:0]   timeout,
   input  logic                  flush,
   rdata_packetizer_if.slave     S_AXIS_RDATA,
   rdata_packetizer_if.master    M_AXIS_RDATA,
   output logic [31:0]           pkt_count,
   output logic [15:0]           short_count,
   output logic                  busy
);

   logic [DATA_WIDTH-1:0] h_data_q, h_data_d, o_data_q, o_data_d;
   logic                  h_vld_q, h_vld_d, h_fin_q, h_fin_d;
   logic                  o_vld_q, o_vld_d, o_last_q, o_last_d;
   logic [LEN_WIDTH-1:0]  idx_q, idx_d, len_q, len_d, len_now;
   logic [TO_WIDTH-1:0]   idle_q, idle_d;
   logic [31:0]           pkt_q, pkt_d;
   logic [15:0]           short_q, short_d;
   logic                  run_q;
   logic                  o_free, s_ready, in_fire, to_hit, close, beat_fin, h_xfer;

   // Handshake terms, beat classification and next state of every register
   always_comb begin
      o_free   = !o_vld_q | M_AXIS_RDATA.tready;
      s_ready  = run_q & (!h_vld_q | o_free);
      in_fire  = S_AXIS_RDATA.tvalid & s_ready;
      to_hit   = (timeout != '0) && (idle_q == timeout);
      close    = h_vld_q & !h_fin_q & (flush | to_hit);
      len_now  = (idx_q == '0) ? ((pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len) : len_q;
      beat_fin = (idx_q == len_now - LEN_WIDTH'(1));
      h_xfer   = 1'b0;

      h_data_d = h_data_q;
      h_vld_d  = h_vld_q;
      h_fin_d  = h_fin_q;
      o_data_d = o_data_q;
      o_vld_d  = o_vld_q;
      o_last_d = o_last_q;
      idx_d    = idx_q;
      len_d    = len_q;
      idle_d   = idle_q;
      pkt_d    = pkt_q;
      short_d  = short_q;

      if (idx_q == '0)
         len_d = len_now;

      if (o_vld_q && M_AXIS_RDATA.tready) begin
         o_vld_d = 1'b0;
         if (o_last_q)
            pkt_d = pkt_q + 32'd1;
      end

      // H moves to O when it is final, displaced by a new beat, or closed.
      // A beat displaced by a new one is never last: the packet continues.
      if (h_vld_q && o_free && (h_fin_q || in_fire || close)) begin
         h_xfer   = 1'b1;
         o_vld_d  = 1'b1;
         o_data_d = h_data_q;
         o_last_d = h_fin_q | (close & !in_fire);
         h_vld_d  = 1'b0;
         h_fin_d  = 1'b0;
      end

      // Close with no new beat: end the packet at the H beat. If O is
      // stalled, mark H final in place so the close is not lost.
      if (close && !in_fire) begin
         idx_d   = '0;
         short_d = short_q + 16'd1;
         if (!o_free)
            h_fin_d = 1'b1;
      end

      // Close coinciding with a new beat ends the packet at the new beat
      if (in_fire) begin
         h_vld_d  = 1'b1;
         h_data_d = S_AXIS_RDATA.tdata;
         h_fin_d  = beat_fin | close;
         idx_d    = (beat_fin | close) ? '0 : idx_q + LEN_WIDTH'(1);
         if (close && !beat_fin)
            short_d = short_q + 16'd1;
      end

      if (in_fire || h_xfer || !h_vld_q || h_fin_q)
         idle_d = '0;
      else if (idle_q != {TO_WIDTH{1'b1}})
         idle_d = idle_q + TO_WIDTH'(1);
   end

   // State registers; reset discards any buffered beats
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         h_data_q <= '0;
         h_vld_q  <= 1'b0;
         h_fin_q  <= 1'b0;
         o_data_q <= '0;
         o_vld_q  <= 1'b0;
         o_last_q <= 1'b0;
         idx_q    <= '0;
         len_q    <= LEN_WIDTH'(1);
         idle_q   <= '0;
         pkt_q    <= '0;
         short_q  <= '0;
         run_q    <= 1'b0;
      end else begin
         h_data_q <= h_data_d;
         h_vld_q  <= h_vld_d;
         h_fin_q  <= h_fin_d;
         o_data_q <= o_data_d;
         o_vld_q  <= o_vld_d;
         o_last_q <= o_last_d;
         idx_q    <= idx_d;
         len_q    <= len_d;
         idle_q   <= idle_d;
         pkt_q    <= pkt_d;
         short_q  <= short_d;
         run_q    <= 1'b1;
      end
   end

   // run_q keeps tready low while reset is held
   assign S_AXIS_RDATA.tready = s_ready;
   assign M_AXIS_RDATA.tdata  = o_data_q;
   assign M_AXIS_RDATA.tkeep  = {(DATA_WIDTH/8){o_vld_q}};
   assign M_AXIS_RDATA.tlast  = o_last_q;
   assign M_AXIS_RDATA.tvalid = o_vld_q;
   assign pkt_count           = pkt_q;
   assign short_count         = short_q;
   assign busy                = h_vld_q | o_vld_q;

endmodule

// File: tb/tb_rdata_packetizer.sv
// Directed bench for rdata_packetizer.
module tb_rdata_packetizer;
   localparam int DW = 512;

   logic        axi_aclk = 1'b0;
   logic        axi_aresetn = 1'b0;
   logic [15:0] pkt_len = 16'd4;
   logic [15:0] timeout = 16'd0;
   logic        flush = 1'b0;
   logic [31:0] pkt_count;
   logic [15:0] short_count;
   logic        busy;

   rdata_packetizer_if #(.DATA_WIDTH(DW)) s_if();
   rdata_packetizer_if #(.DATA_WIDTH(DW)) m_if();

   rdata_packetizer #(.DATA_WIDTH(DW), .LEN_WIDTH(16), .TO_WIDTH(16)) dut (
      .axi_aclk     (axi_aclk),
      .axi_aresetn  (axi_aresetn),
      .pkt_len      (pkt_len),
      .timeout      (timeout),
      .flush        (flush),
      .S_AXIS_RDATA (s_if),
      .M_AXIS_RDATA (m_if),
      .pkt_count    (pkt_count),
      .short_count  (short_count),
      .busy         (busy)
   );

   always #5 axi_aclk = ~axi_aclk;

   typedef struct { logic [DW-1:0] d; logic l; int c; } beat_t;
   beat_t q[$];
   int total = 0, bad = 0;
   int cyc = 0, acc_cnt = 0, acc_cyc = 0;
   int keep_bad = 0, stab_bad = 0;
   logic stalled = 1'b0;
   logic [DW-1:0] st_d = '0;
   logic st_l = 1'b0;

   always @(posedge axi_aclk) cyc <= cyc + 1;

   // Output monitor: records handshakes, checks tkeep and stall stability
   always @(negedge axi_aclk) begin
      if (axi_aresetn && stalled &&
          (m_if.tvalid !== 1'b1 || m_if.tdata !== st_d || m_if.tlast !== st_l))
         stab_bad <= stab_bad + 1;
      stalled <= axi_aresetn & m_if.tvalid & !m_if.tready;
      st_d    <= m_if.tdata;
      st_l    <= m_if.tlast;
      if (m_if.tvalid === 1'b1 && m_if.tkeep !== '1)
         keep_bad <= keep_bad + 1;
      if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1)
         q.push_back('{m_if.tdata, m_if.tlast, cyc});
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge axi_aclk);
      #1;
   endtask

   // Present one beat and return #1 after the edge that accepts it
   task automatic push(input logic [DW-1:0] d);
      int n = 0;
      s_if.tdata  = d;
      s_if.tvalid = 1'b1;
      @(negedge axi_aclk);
      while (s_if.tready !== 1'b1 && n < 200) begin
         @(negedge axi_aclk);
         n++;
      end
      if (n >= 200) begin
         total++; bad++;
         $display("FAIL push_timeout beat=%0h never accepted", d);
      end else begin
         @(posedge axi_aclk);
         #1;
         acc_cnt++;
         acc_cyc = cyc;
      end
   endtask

   task automatic test_reset();
      #12;
      total++;
      if ({m_if.tvalid, m_if.tlast, s_if.tready, busy} !== 4'b0) begin
         bad++; $display("FAIL rst_outputs got=%b exp=0000", {m_if.tvalid, m_if.tlast, s_if.tready, busy});
      end
      total++;
      if (pkt_count !== 32'd0 || short_count !== 16'd0 || m_if.tkeep !== '0) begin
         bad++; $display("FAIL rst_counters got pkt=%0d short=%0d exp 0/0", pkt_count, short_count);
      end
      @(posedge axi_aclk); #1;
      axi_aresetn = 1'b1;
      cycles(1);
      total++;
      if (s_if.tready !== 1'b1) begin
         bad++; $display("FAIL rst_release_tready got=%b exp=1", s_if.tready);
      end
   endtask

   task automatic test_exact();
      pkt_len = 16'd4; timeout = 16'd0; m_if.tready = 1'b1; q.delete();
      for (int i = 0; i < 8; i++) push(DW'(32'h10 + i));
      s_if.tvalid = 1'b0;
      for (int i = 0; i < 50 && q.size() < 8; i++) cycles(1);
      total++;
      if (q.size() != 8) begin
         bad++; $display("FAIL exact_count got=%0d exp=8", q.size());
      end
      for (int i = 0; i < q.size(); i++) begin
         total++;
         if (q[i].d !== DW'(32'h10 + i) || q[i].l !== (i == 3 || i == 7)) begin
            bad++; $display("FAIL exact_beat%0d got d=%0h l=%b exp d=%0h l=%b",
                            i, q[i].d, q[i].l, 32'h10 + i, (i == 3 || i == 7));
         end
      end
      total++;
      if (keep_bad !== 0) begin
         bad++; $display("FAIL exact_tkeep got=%0d bad beats exp=0", keep_bad);
      end
      total++;
      if (pkt_count !== 32'd2 || short_count !== 16'd0) begin
         bad++; $display("FAIL exact_counters got pkt=%0d short=%0d exp 2/0", pkt_count, short_count);
      end
   endtask

   task automatic test_flush();
      pkt_len = 16'd8; q.delete();
      for (int i = 0; i < 3; i++) push(DW'(32'h20 + i));
      s_if.tvalid = 1'b0;
      cycles(3);
      total++;
      if (q.size() != 2) begin
         bad++; $display("FAIL flush_hold got=%0d beats exp=2", q.size());
      end
      flush = 1'b1; cycles(1); flush = 1'b0;
      for (int i = 0; i < 20 && q.size() < 3; i++) cycles(1);
      total++;
      if (q.size() != 3 || q[2].d !== DW'(32'h22) || q[2].l !== 1'b1) begin
         bad++; $display("FAIL flush_close got n=%0d exp n=3 with d=22 l=1", q.size());
      end
      total++;
      if (short_count !== 16'd1) begin
         bad++; $display("FAIL flush_short got=%0d exp=1", short_count);
      end
      pkt_len = 16'd2;
      push(DW'(32'h23)); push(DW'(32'h24));
      s_if.tvalid = 1'b0;
      for (int i = 0; i < 20 && q.size() < 5; i++) cycles(1);
      total++;
      if (q.size() != 5 || q[3].l !== 1'b0 || q[4].d !== DW'(32'h24) || q[4].l !== 1'b1) begin
         bad++; $display("FAIL flush_newpkt got n=%0d exp n=5 with 23/l0 24/l1", q.size());
      end
      total++;
      if (pkt_count !== 32'd4) begin
         bad++; $display("FAIL flush_pkt got=%0d exp=4", pkt_count);
      end
   endtask

   task automatic test_timeout();
      int t1;
      pkt_len = 16'd8; timeout = 16'd5; q.delete();
      push(DW'(32'h30)); push(DW'(32'h31)); t1 = acc_cyc;
      s_if.tvalid = 1'b0;
      for (int i = 0; i < 30 && q.size() < 2; i++) cycles(1);
      total++;
      if (q.size() != 2 || q[1].d !== DW'(32'h31) || q[1].l !== 1'b1) begin
         bad++; $display("FAIL to_close got n=%0d exp n=2 with d=31 l=1", q.size());
      end
      total++;
      if (q.size() == 2 && q[1].c - t1 != 6) begin
         bad++; $display("FAIL to_latency got=%0d exp=6", q[1].c - t1);
      end
      total++;
      if (short_count !== 16'd2) begin
         bad++; $display("FAIL to_short got=%0d exp=2", short_count);
      end
      timeout = 16'd0; q.delete();
      push(DW'(32'h32)); push(DW'(32'h33));
      s_if.tvalid = 1'b0;
      cycles(30);
      total++;
      if (q.size() != 1 || busy !== 1'b1) begin
         bad++; $display("FAIL to_disabled got n=%0d busy=%b exp n=1 busy=1", q.size(), busy);
      end
      flush = 1'b1; cycles(1); flush = 1'b0;
      for (int i = 0; i < 20 && q.size() < 2; i++) cycles(1);
      total++;
      if (q.size() != 2 || q[1].d !== DW'(32'h33) || q[1].l !== 1'b1 || short_count !== 16'd3) begin
         bad++; $display("FAIL to_cleanup got n=%0d short=%0d exp n=2 short=3", q.size(), short_count);
      end
   endtask

   task automatic test_backpressure();
      pkt_len = 16'd2; timeout = 16'd0; m_if.tready = 1'b0; q.delete(); acc_cnt = 0;
      fork
         begin
            for (int i = 0; i < 6; i++) push(DW'(32'h40 + i));
            s_if.tvalid = 1'b0;
         end
         begin
            cycles(5);
            total++;
            if (acc_cnt != 2 || s_if.tready !== 1'b0 || q.size() != 0) begin
               bad++; $display("FAIL bp_stall got acc=%0d tready=%b out=%0d exp 2/0/0",
                               acc_cnt, s_if.tready, q.size());
            end
            cycles(5);
            m_if.tready = 1'b1;
         end
      join
      for (int i = 0; i < 30 && q.size() < 6; i++) cycles(1);
      total++;
      if (q.size() != 6) begin
         bad++; $display("FAIL bp_count got=%0d exp=6", q.size());
      end
      for (int i = 0; i < q.size(); i++) begin
         total++;
         if (q[i].d !== DW'(32'h40 + i) || q[i].l !== (i % 2 == 1)) begin
            bad++; $display("FAIL bp_beat%0d got d=%0h l=%b exp d=%0h l=%b",
                            i, q[i].d, q[i].l, 32'h40 + i, (i % 2 == 1));
         end
      end
      total++;
      if (stab_bad != 0 || pkt_count !== 32'd9) begin
         bad++; $display("FAIL bp_stable got unstable=%0d pkt=%0d exp 0/9", stab_bad, pkt_count);
      end
   endtask

   task automatic test_simul_flush();
      pkt_len = 16'd8; q.delete();
      push(DW'(32'h50)); push(DW'(32'h51));
      flush = 1'b1;
      push(DW'(32'h52));
      flush = 1'b0; s_if.tvalid = 1'b0;
      for (int i = 0; i < 20 && q.size() < 3; i++) cycles(1);
      total++;
      if (q.size() != 3 || q[1].d !== DW'(32'h51) || q[1].l !== 1'b0) begin
         bad++; $display("FAIL sim_old got n=%0d exp n=3 with d=51 l=0", q.size());
      end
      total++;
      if (q.size() == 3 && (q[2].d !== DW'(32'h52) || q[2].l !== 1'b1)) begin
         bad++; $display("FAIL sim_new got d=%0h l=%b exp d=52 l=1", q[2].d, q[2].l);
      end
      total++;
      if (short_count !== 16'd4 || pkt_count !== 32'd10) begin
         bad++; $display("FAIL sim_counters got short=%0d pkt=%0d exp 4/10", short_count, pkt_count);
      end
   endtask

   task automatic test_reset_len();
      pkt_len = 16'd8; m_if.tready = 1'b0;
      push(DW'(32'h60)); push(DW'(32'h61));
      s_if.tvalid = 1'b0;
      cycles(1);
      total++;
      if (busy !== 1'b1 || m_if.tvalid !== 1'b1) begin
         bad++; $display("FAIL rl_pre got busy=%b tvalid=%b exp 1/1", busy, m_if.tvalid);
      end
      #2 axi_aresetn = 1'b0;
      #1;
      total++;
      if ({m_if.tvalid, m_if.tlast, s_if.tready, busy} !== 4'b0 || m_if.tkeep !== '0 ||
          pkt_count !== 32'd0 || short_count !== 16'd0) begin
         bad++; $display("FAIL rl_async got v/l/r/b=%b pkt=%0d short=%0d exp all 0",
                         {m_if.tvalid, m_if.tlast, s_if.tready, busy}, pkt_count, short_count);
      end
      m_if.tready = 1'b1;
      @(posedge axi_aclk); #1;
      axi_aresetn = 1'b1;
      cycles(1);
      q.delete(); pkt_len = 16'd0;
      for (int i = 0; i < 3; i++) push(DW'(32'h70 + i));
      s_if.tvalid = 1'b0;
      for (int i = 0; i < 20 && q.size() < 3; i++) cycles(1);
      total++;
      if (q.size() != 3) begin
         bad++; $display("FAIL rl_len0_count got=%0d exp=3", q.size());
      end
      for (int i = 0; i < q.size(); i++) begin
         total++;
         if (q[i].d !== DW'(32'h70 + i) || q[i].l !== 1'b1) begin
            bad++; $display("FAIL rl_len0_beat%0d got d=%0h l=%b exp d=%0h l=1", i, q[i].d, q[i].l, 32'h70 + i);
         end
      end
      total++;
      if (pkt_count !== 32'd3) begin
         bad++; $display("FAIL rl_pkt got=%0d exp=3", pkt_count);
      end
   endtask

   initial begin
      s_if.tdata = '0; s_if.tvalid = 1'b0; s_if.tkeep = '0; s_if.tlast = 1'b0;
      m_if.tready = 1'b0;
      test_reset();
      test_exact();
      test_flush();
      test_timeout();
      test_backpressure();
      test_simul_flush();
      test_reset_len();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end
endmodule

// File: doc/rdata_packetizer.md
# rdata_packetizer

Framing stage between the sddt_core read-data output and the PS S2MM DMA input. It accepts an unframed 512-bit read-data beat stream and emits AXI-Stream packets of a programmable beat count with tlast and tkeep. Partial packets are closed by an explicit flush pulse or by an idle timeout, so the DMA never stalls waiting for a tlast that will not come. The block holds at most two beats: a decision register and an output register.

## Interface
Parameters:
- DATA_WIDTH, 512, read-data beat width; tkeep width is DATA_WIDTH/8.
- LEN_WIDTH, 16, width of pkt_len and the beat index counter.
- TO_WIDTH, 16, width of timeout and the idle counter.

Ports:
- axi_aclk  in  1  single clock; all logic is on its rising edge.
- axi_aresetn  in  1  asynchronous, active-low reset.
- pkt_len  in  LEN_WIDTH  beats per packet; sampled on the first beat of each packet; 0 is treated as 1.
- timeout  in  TO_WIDTH  idle cycles before a partial packet is closed; 0 disables the timeout.
- flush  in  1  single-cycle pulse that closes the current partial packet.
- S_AXIS_RDATA_tdata  in  DATA_WIDTH  input beat.
- S_AXIS_RDATA_tvalid  in  1  input valid.
- S_AXIS_RDATA_tready  out  1  input ready.
- M_AXIS_RDATA_tdata  out  DATA_WIDTH  output beat.
- M_AXIS_RDATA_tkeep  out  DATA_WIDTH/8  all ones whenever tvalid is high.
- M_AXIS_RDATA_tlast  out  1  marks the last beat of a packet.
- M_AXIS_RDATA_tvalid  out  1  output valid.
- M_AXIS_RDATA_tready  in  1  output ready.
- pkt_count  out  32  packets completed (tlast handshakes); wraps at 2^32.
- short_count  out  16  packets closed by flush or timeout; wraps at 2^16.
- busy  out  1  H_valid | O_valid.

## Operation
Registers:
- **H**: decision register. Fields: data, valid, final.
- **O**: output register. Fields: data, valid, last.
- **idx**: beat index within the current packet (LEN_WIDTH bits).
- **len_q**: latched packet length.
- **idle**: idle counter (TO_WIDTH bits).

Control terms:
- o_free = !O_valid | M_tready.
- S_tready = !H_valid | o_free.
- in_fire = S_tvalid & S_tready.
- close = H_valid & !H_final & (flush | (timeout != 0 & idle == timeout)).

Beat acceptance:
- When idx == 0, len_q <= max(pkt_len, 1).
- The accepted beat's length is taken as the value just latched when idx == 0, otherwise len_q.
- On in_fire the beat enters H with final = (idx == length − 1).
- idx increments, or returns to 0 when the beat is final.

H → O transfer (only when o_free):
- H_final: O.last = 1.
- in_fire: O.last = 0. This case cannot coincide with H_final being 0 and the new beat being the same beat.
- close: O.last = 1; idx <= 0.
- Otherwise H stays; O.valid clears when M_tready.

Invariant:
- Any packet with idx ≠ 0 has its most recent beat in H with final = 0.
- Therefore a flush while H is empty has no effect.

Idle counter:
- Clears on in_fire or on any H transfer.
- Increments, saturating, while H holds a non-final beat.

Simultaneous events:
- flush + in_fire with H non-final: the old H beat goes out with tlast = 0, the new beat enters H marked final, idx <= 0, and short_count increments once, unless the new beat was already final by count. A "close" in this case applies to the incoming beat.
- flush + timeout in the same cycle: a single close; short_count +1.
- flush while H_final is already set: ignored.

Counters:
- pkt_count increments on M_tvalid & M_tready & M_tlast.
- short_count increments when a packet is closed by flush or timeout (a forced final).

Reset (asynchronous, any time):
- H, O, idx, idle, counters <= 0; len_q <= 1.
- All outputs are 0, including tready.
- In-flight beats are discarded.

## Timing
- Latency for a final beat: accepted at edge k → in H after k → O loaded at edge k+1 → M_tvalid high in the cycle after k+1, assuming O is free.
- A non-final beat leaves H when the next input beat is accepted, or on a close.
- Sustained throughput is 1 beat/cycle when M_tready is held high.
- Timeout close: with timeout = T, a non-final beat in H with no input is emitted with tlast = 1 on the edge after idle reaches T.
- Backpressure: O holds tdata and tlast stable while tvalid & !tready. S_tready falls when both H and O are occupied and M_tready is low.

## Test plan
- **Exact packets:** pkt_len = 4, 8 back-to-back beats D0..D7, M_tready = 1 → tlast on D3 and D7 only; tkeep = all ones; pkt_count = 2; short_count = 0.
- **Flush close:** pkt_len = 8, 3 beats, then flush → D2 emitted with tlast = 1; short_count = 1; the next beat starts a new packet at idx = 0.
- **Timeout close:** pkt_len = 8, timeout = 5, 2 beats then idle → D1 emitted with tlast = 1, 6 cycles after its acceptance; timeout = 0 with the same stimulus → D1 never emitted.
- **Backpressure:** pkt_len = 2, M_tready held low 10 cycles during a 6-beat burst → S_tready drops after 2 beats are buffered; output order D0..D5 is intact with tlast on D1, D3 and D5; no loss or duplication.
- **Simultaneous flush:** flush coincident with beat D2 (pkt_len = 8) → D1 emitted with tlast = 0, D2 with tlast = 1; short_count = 1.
- **Reset and length edge cases:** axi_aresetn low mid-packet → all outputs 0 immediately, counters cleared; after release pkt_len = 0 → every beat carries tlast.
